// File: rtl/fetch_instr_queue.sv
// Fetch -> decode decoupling FIFO.
// Holds {Instr, PC, PCPlus4} triples in a small register array with valid/ready on both
// sides. A redirect flush empties the queue in one edge. An empty queue presents a NOP bubble.
// Optional statistics (stall counter, occupancy high-water mark) are compiled in when the
// macro FETCH_QUEUE_STATS_EN is defined.
module fetch_instr_queue #(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    // Fetch side
    input  logic                       valid_i,
    input  logic [DATA_WIDTH-1:0]      Instr_i,
    input  logic [DATA_WIDTH-1:0]      PC_i,
    input  logic [DATA_WIDTH-1:0]      PCPlus4_i,
    output logic                       ready_o,
    // Decode side
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [DATA_WIDTH-1:0]      Instr_o,
    output logic [DATA_WIDTH-1:0]      PC_o,
    output logic [DATA_WIDTH-1:0]      PCPlus4_o,
    output logic [$clog2(DEPTH):0]     count_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]                stall_cnt_o,
    output logic [$clog2(DEPTH):0]     max_count_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Storage, intentionally not reset: contents are only observable through count.
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] pc4_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake decode; flush cancels any transfer offered in the same cycle.
    always_comb begin
        full    = (count_q == CNT_FULL);
        empty   = (count_q == '0);
        ready_o = rst_n & ~full;
        valid_o = rst_n & ~empty;
        push    = valid_i & ready_o & ~flush_i;
        pop     = valid_o & ready_i & ~flush_i;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset dominates flush, push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write; push is already qualified by reset and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= Instr_i;
            pc_mem[wr_ptr_q]    <= PC_i;
            pc4_mem[wr_ptr_q]   <= PCPlus4_i;
        end
    end

    // Head presentation; bubble values whenever nothing valid is at the head.
    always_comb begin
        if (valid_o) begin
            Instr_o   = instr_mem[rd_ptr_q];
            PC_o      = pc_mem[rd_ptr_q];
            PCPlus4_o = pc4_mem[rd_ptr_q];
        end else begin
            Instr_o   = NOP_INSTR;
            PC_o      = '0;
            PCPlus4_o = '0;
        end
        count_o = rst_n ? count_q : '0;
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0]      stall_cnt_q;
    logic [CNT_W-1:0] max_count_q;

    // Stall counter saturates; high-water mark tracks next occupancy so it is never stale.
    // Flush deliberately leaves both untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            max_count_q <= '0;
        end else begin
            if (valid_i && !ready_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (count_d > max_count_q) begin
                max_count_q <= count_d;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign max_count_o = max_count_q;
`endif

endmodule

// File: tb/tb_fetch_instr_queue.sv
// Scoreboard bench for fetch_instr_queue: stimulus enqueues expected triples, a negedge
// monitor checks the head and retires entries on each decode handshake.
module tb_fetch_instr_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] Instr_i;
    logic [31:0] PC_i;
    logic [31:0] PCPlus4_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] Instr_o;
    logic [31:0] PC_o;
    logic [31:0] PCPlus4_o;
    logic [2:0]  count_o;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cnt_o;
    logic [2:0]  max_count_o;
`endif

    fetch_instr_queue #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .Instr_i    (Instr_i),
        .PC_i       (PC_i),
        .PCPlus4_i  (PCPlus4_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .Instr_o    (Instr_o),
        .PC_o       (PC_o),
        .PCPlus4_o  (PCPlus4_o),
        .count_o    (count_o)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stall_cnt_o (stall_cnt_o),
        .max_count_o (max_count_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    entry_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    bit     mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: head must match the oldest expected entry; bubble values when empty.
    always @(negedge clk) begin
        if (mon_on && !flush_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    check("head_instr", Instr_o, exp_q[0].instr);
                    check("head_pc", PC_o, exp_q[0].pc);
                    check("head_pc4", PCPlus4_o, exp_q[0].pc4);
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("bubble", {Instr_o ^ NOP, PC_o | PCPlus4_o} == '0 ? 32'd1 : 32'd0, 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of fetch/decode stimulus; 'take' marks a push known to be accepted.
    task automatic drive(input logic v, input logic r, input logic [31:0] ins,
                         input logic [31:0] pc, input logic take);
        valid_i   = v;
        ready_i   = r;
        Instr_i   = ins;
        PC_i      = pc;
        PCPlus4_i = pc + 32'd4;
        if (take) begin
            exp_q.push_back('{instr: ins, pc: pc, pc4: pc + 32'd4});
        end
        cyc();
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < cycles; i++) begin
            cyc();
        end
        rst_n   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        cyc();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        valid_i   = 1'b1;
        ready_i   = 1'b0;
        Instr_i   = 32'hDEAD_BEEF;
        PC_i      = 32'h0000_0040;
        PCPlus4_i = 32'h0000_0044;

        // 1: reset held 3 cycles with valid_i high
        for (int i = 0; i < 3; i++) begin
            cyc();
            mon_on = 1'b1;
            check("rst_valid_o", {31'd0, valid_o}, 32'd0);
            check("rst_ready_o", {31'd0, ready_o}, 32'd0);
            check("rst_instr_o", Instr_o, NOP);
            check("rst_count_o", {29'd0, count_o}, 32'd0);
        end
        rst_n   = 1'b1;
        valid_i = 1'b0;
        cyc();
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check("post_rst_count", {29'd0, count_o}, 32'd0);

        // 2: ordering
        drive(1'b1, 1'b0, 32'h0050_0093, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 32'h00A0_0113, 32'h4, 1'b1);
        valid_i = 1'b0;
        check("order_count2", {29'd0, count_o}, 32'd2);
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("order_valid_after", {31'd0, valid_o}, 32'd0);
        check("order_count0", {29'd0, count_o}, 32'd0);

        // 3: full
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h0010_0093 + (32'(i) << 20), 32'h10 + 32'(i) * 4, 1'b1);
        end
        check("full_ready", {31'd0, ready_o}, 32'd0);
        check("full_count", {29'd0, count_o}, 32'd4);
        drive(1'b1, 1'b0, 32'h0BAD_0013, 32'h90, 1'b0);
        check("full_drop_count", {29'd0, count_o}, 32'd4);
        drive(1'b1, 1'b1, 32'h0550_0093, 32'h20, 1'b0);
        check("full_pop_count", {29'd0, count_o}, 32'd3);
        check("full_pop_ready", {31'd0, ready_o}, 32'd1);
        drive(1'b1, 1'b0, 32'h0550_0093, 32'h20, 1'b1);
        check("full_refill_count", {29'd0, count_o}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        end
        check("full_drain_count", {29'd0, count_o}, 32'd0);

        // 4: streaming, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'h1000_0013 + 32'(i), 32'h100 + 32'(i) * 4, 1'b1);
            check("stream_count", {29'd0, count_o}, 32'd1);
        end
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("stream_end_count", {29'd0, count_o}, 32'd0);
        ready_i = 1'b0;

        // 5: flush with a concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h2000_0013 + 32'(i), 32'h200 + 32'(i) * 4, 1'b1);
        end
        check("flush_pre_count", {29'd0, count_o}, 32'd3);
        flush_i = 1'b1;
        exp_q.delete();
        drive(1'b1, 1'b1, 32'h0FFF_0013, 32'h300, 1'b0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        check("flush_count", {29'd0, count_o}, 32'd0);
        check("flush_valid", {31'd0, valid_o}, 32'd0);
        check("flush_instr", Instr_o, NOP);
        drive(1'b1, 1'b0, 32'h0030_0193, 32'h400, 1'b1);
        drive(1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
        check("post_flush_count", {29'd0, count_o}, 32'd0);
        ready_i = 1'b0;

        // Reset mid-stream drops stored entries
        drive(1'b1, 1'b0, 32'h0040_0213, 32'h500, 1'b1);
        drive(1'b1, 1'b0, 32'h0040_0293, 32'h504, 1'b1);
        rst_n   = 1'b0;
        valid_i = 1'b1;
        exp_q.delete();
        cyc();
        check("midrst_ready", {31'd0, ready_o}, 32'd0);
        check("midrst_count", {29'd0, count_o}, 32'd0);
        rst_n   = 1'b1;
        valid_i = 1'b0;
        cyc();
        check("midrst_ready_back", {31'd0, ready_o}, 32'd1);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);

`ifdef FETCH_QUEUE_STATS_EN
        // 6: statistics
        apply_reset(1);
        check("stats_rst_stall", stall_cnt_o, 32'd0);
        check("stats_rst_max", {29'd0, max_count_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h3000_0013 + 32'(i), 32'h600 + 32'(i) * 4, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h3FFF_0013, 32'h700, 1'b0);
        end
        valid_i = 1'b0;
        check("stats_stall", stall_cnt_o, 32'd5);
        check("stats_max", {29'd0, max_count_o}, 32'd4);
        flush_i = 1'b1;
        exp_q.delete();
        cyc();
        flush_i = 1'b0;
        check("stats_flush_count", {29'd0, count_o}, 32'd0);
        check("stats_flush_stall", stall_cnt_o, 32'd5);
        check("stats_flush_max", {29'd0, max_count_o}, 32'd4);
`endif

        cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
